serial_subtractor: RTL and testbench

Multi-cycle, digit-serial subtractor that computes D = A − B − Bin over WIDTH/DIGIT clock cycles and reports the final borrow. It complements the combinational ripple adders in the arithmetic datapath. It trades latency for a narrow per-cycle subtract slice of DIGIT bits. Operands are accepted with a start/busy/done handshake, so a controller FSM can issue operations and collect results.

---
 rtl/serial_subtractor_if.sv | 37 +++
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for serial_subtractor.
// Optional V port appears when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, V
    );
`else
    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bin over WIDTH/DIGIT cycles.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output V.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
    logic [DIGIT:0]   dsub;
    logic [WIDTH-1:0] d_nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic             am;
    logic             bm;
    logic             v_q;
`endif

    // One digit slice: subtract with borrow, then insert it at the D MSB end.
    always_comb begin
        dsub  = {1'b0, a_sh[DIGIT-1:0]}
              - {1'b0, b_sh[DIGIT-1:0]}
              - {{DIGIT{1'b0}}, brw};
        d_nxt = (d_q >> DIGIT)
              | (WIDTH'(dsub[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // Control FSM with all datapath and handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            d_q    <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am     <= 1'b0;
            bm     <= 1'b0;
            v_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.B;
                        brw    <= bus.Bin;
                        cnt    <= CW'(N - 1);
                        d_q    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        am     <= bus.A[WIDTH-1];
                        bm     <= bus.B[WIDTH-1];
                        v_q    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    d_q    <= d_nxt;
                    brw    <= dsub[DIGIT];
                    bout_q <= dsub[DIGIT];
                    if (cnt == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        v_q    <= (am ^ bm) & (am ^ d_nxt[WIDTH-1]);
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.V    = v_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (4/1, 8/2 and 8/8 builds).
// V checks are compiled in when SERIAL_SUB_OVF_EN is defined.
`timescale 1ns/1ps
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   npass = 0;
    int   nfail = 0;
    int   ntot  = 0;
    logic last_bout = 1'b0;
    logic [31:0] q4[$];
    logic [31:0] q8[$];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(8)) bus8a ();
    serial_subtractor_if #(.WIDTH(8)) bus8b ();

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u4 (
        .clk(clk), .reset(reset), .bus(bus4.slave)
    );
    serial_subtractor #(.WIDTH(8), .DIGIT(2)) u8a (
        .clk(clk), .reset(reset), .bus(bus8a.slave)
    );
    serial_subtractor #(.WIDTH(8), .DIGIT(8)) u8b (
        .clk(clk), .reset(reset), .bus(bus8b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic bin);
        logic [4:0]  r;
        logic [31:0] e;
        logic        v;
        int          cyc;
        r = {1'b0, a} - {1'b0, b} - {4'b0, bin};
        v = (a[3] ^ b[3]) & (a[3] ^ r[3]);
        @(negedge clk);
        bus4.A = a;
        bus4.B = b;
        bus4.Bin = bin;
        bus4.start = 1'b1;
        q4.push_back({26'b0, v, r[4], r[3:0]});
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        chk("accept_busy", 32'(bus4.busy), 1);
        chk("accept_dclr", 32'(bus4.D), 0);
        chk("accept_bout_hold", 32'(bus4.Bout), 32'(last_bout));
        cyc = 0;
        while (bus4.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("lat4", cyc, 4);
        e = q4.pop_front();
        chk("d4", 32'(bus4.D), 32'(e[3:0]));
        chk("bout4", 32'(bus4.Bout), 32'(e[4]));
        chk("busy_in_done", 32'(bus4.busy), 1);
`ifdef SERIAL_SUB_OVF_EN
        chk("v4", 32'(bus4.V), 32'(e[5]));
`endif
        last_bout = bus4.Bout;
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(bus4.done), 0);
        chk("busy_fall", 32'(bus4.busy), 0);
        chk("d_hold", 32'(bus4.D), 32'(e[3:0]));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic bin);
        logic [8:0]  r;
        logic [31:0] e;
        int          cyc;
        int          la;
        int          lb;
        r = {1'b0, a} - {1'b0, b} - {8'b0, bin};
        @(negedge clk);
        bus8a.A = a; bus8a.B = b; bus8a.Bin = bin; bus8a.start = 1'b1;
        bus8b.A = a; bus8b.B = b; bus8b.Bin = bin; bus8b.start = 1'b1;
        q8.push_back({23'b0, r});
        @(posedge clk);
        #1;
        bus8a.start = 1'b0;
        bus8b.start = 1'b0;
        e = q8[0];
        la = -1;
        lb = -1;
        cyc = 0;
        while ((la < 0 || lb < 0) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus8a.done === 1'b1 && la < 0) begin
                la = cyc;
                chk("d8_dig2", 32'(bus8a.D), 32'(e[7:0]));
                chk("bout8_dig2", 32'(bus8a.Bout), 32'(e[8]));
            end
            if (bus8b.done === 1'b1 && lb < 0) begin
                lb = cyc;
                chk("d8_dig8", 32'(bus8b.D), 32'(e[7:0]));
                chk("bout8_dig8", 32'(bus8b.Bout), 32'(e[8]));
            end
        end
        void'(q8.pop_front());
        chk("lat8_dig2", la, 4);
        chk("lat8_dig8", lb, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ndone;
        bus4.start = 0; bus4.A = 0; bus4.B = 0; bus4.Bin = 0;
        bus8a.start = 0; bus8a.A = 0; bus8a.B = 0; bus8a.Bin = 0;
        bus8b.start = 0; bus8b.A = 0; bus8b.B = 0; bus8b.Bin = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus4.busy), 0);
        chk("rst_done", 32'(bus4.done), 0);
        chk("rst_d", 32'(bus4.D), 0);
        chk("rst_bout", 32'(bus4.Bout), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_v", 32'(bus4.V), 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        op4(4'd9, 4'd3, 1'b0);
        op4(4'd3, 4'd9, 1'b0);
        op4(4'd0, 4'd0, 1'b1);

        // start during RUN and DONE must be ignored
        @(negedge clk);
        bus4.A = 4'd7; bus4.B = 4'd2; bus4.Bin = 1'b0; bus4.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus4.A = 4'd1; bus4.B = 4'd5; bus4.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("ign_done", 32'(bus4.done), 1);
        chk("ign_busy_done", 32'(bus4.busy), 1);
        chk("ign_d", 32'(bus4.D), 5);
        @(negedge clk);
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        chk("ign_busy_fall", 32'(bus4.busy), 0);
        chk("ign_done_fall", 32'(bus4.done), 0);
        @(negedge clk);
        bus4.start = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus4.done === 1'b1) ndone++;
        end
        chk("ign_no_second_done", ndone, 0);
        chk("ign_d_hold", 32'(bus4.D), 5);
        last_bout = 1'b0;

        // reset on the second RUN cycle aborts
        @(negedge clk);
        bus4.A = 4'd15; bus4.B = 4'd0; bus4.Bin = 1'b0; bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus4.busy), 0);
        chk("abort_done", 32'(bus4.done), 0);
        chk("abort_d", 32'(bus4.D), 0);
        chk("abort_bout", 32'(bus4.Bout), 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus4.done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        last_bout = 1'b0;
        op4(4'd12, 4'd4, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        op4(4'd8, 4'd1, 1'b0);
        op4(4'd5, 4'd2, 1'b0);
        op4(4'd7, 4'd8, 1'b1);
`endif

        op8(8'd0, 8'd0, 1'b0);
        op8(8'd0, 8'd0, 1'b1);
        op8(8'd255, 8'd255, 1'b1);
        op8(8'd255, 8'd0, 1'b0);
        op8(8'd0, 8'd255, 1'b1);
        op8(8'd128, 8'd127, 1'b0);
        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
